// File: rtl/core_dbus_bridge_pkg.sv
// Types and constants shared between the data-bus bridge and core_MEM.
// Holds the bridge state encoding, memory access-size codes and the alignment rule.
package structures;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } dbus_state_t;

   localparam logic [1:0] MEM_TYPE_NONE   = 2'd0;
   localparam logic [1:0] MEM_TYPE_BYTE   = 2'd1;
   localparam logic [1:0] MEM_TYPE_WORD   = 2'd2;
   localparam logic [1:0] MEM_TYPE_DOUBLE = 2'd3;

   // Bytes may sit at any address; words need 4-byte and doublewords 8-byte alignment.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] low);
      return ((size == MEM_TYPE_WORD)   && (low[1:0] != 2'b00)) ||
             ((size == MEM_TYPE_DOUBLE) && (low      != 3'b000));
   endfunction

endpackage

// File: rtl/core_dbus_bridge_load_extend.sv
// Size and sign extension of right-aligned load data.
// This is purely combinational: a byte or word is zero- or sign-extended and a doubleword passes through.
module load_extend
   import structures::*;
(
   input  logic [63:0] i_data,
   input  logic [1:0]  i_size,
   input  logic        i_signed,
   output logic [63:0] o_data
);

   // NOTE: o_data gets a default before the case so that every path assigns it and no latch is inferred.
   always_comb begin
      o_data = i_data;
      case (i_size)
         MEM_TYPE_BYTE: o_data = {{56{i_signed & i_data[7]}},  i_data[7:0]};
         MEM_TYPE_WORD: o_data = {{32{i_signed & i_data[31]}}, i_data[31:0]};
         default:       o_data = i_data;
      endcase
   end

endmodule

// File: rtl/core_dbus_bridge.sv
// MMIO bridge between the EX/MEM boundary and the peripheral data bus.
// It diverts window hits to a req/ack transaction and stalls the pipeline until that transaction completes.
module core_dbus_bridge
   import structures::*;
#(
   parameter logic [63:0] MMIO_BASE = 64'h0000_0000_FFFF_0000,
   parameter logic [63:0] MMIO_MASK = 64'hFFFF_FFFF_FFFF_0000,
   parameter int          TIMEOUT   = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [63:0] addr,
   input  logic [63:0] wdata,
   input  logic [1:0]  load_type,
   input  logic [1:0]  store_type,
   input  logic        load_signed,
   output logic        d_ready,
   output logic        d_valid,
   output logic [63:0] d_rdata,
   output logic        stall,
   output logic        bus_fault,
   output logic        bus_req,
   output logic        bus_we,
   output logic [63:0] bus_addr,
   output logic [63:0] bus_wdata,
   output logic [1:0]  bus_size,
   input  logic        bus_ack,
   input  logic        bus_err,
   input  logic [63:0] bus_rdata
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

   dbus_state_t r_state, w_state_next;
   logic [63:0] r_addr, r_wdata, r_rdata;
   logic [1:0]  r_size;
   logic        r_we, r_signed, r_fault;
   logic [CW-1:0] r_count;

   logic        w_is_store, w_hit, w_misaligned;
   logic [1:0]  w_size;
   logic [63:0] w_ext;

   // A store takes precedence when both type fields are nonzero.
   assign w_is_store   = |store_type;
   assign w_size       = w_is_store ? store_type : load_type;
   assign w_hit        = (|load_type | |store_type) & ((addr & MMIO_MASK) == MMIO_BASE);
   assign w_misaligned = is_misaligned(w_size, addr[2:0]);

   // NOTE: state and latches update with non-blocking assignments so that every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_hit) w_state_next = w_misaligned ? RESP : REQ;
         REQ:     if (bus_err || bus_ack || (r_count == LAST_WAIT)) w_state_next = RESP;
         RESP:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_size   <= MEM_TYPE_NONE;
         r_we     <= 1'b0;
         r_signed <= 1'b0;
         r_fault  <= 1'b0;
         r_count  <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_hit) begin
               r_addr   <= addr;
               r_wdata  <= wdata;
               r_size   <= w_size;
               r_we     <= w_is_store;
               r_signed <= load_signed;
               r_fault  <= w_misaligned;
               r_rdata  <= '0;
               r_count  <= '0;
            end
            // An error wins over a simultaneous ack.
            REQ: begin
               if (bus_err)                     r_fault <= 1'b1;
               else if (bus_ack)                r_rdata <= bus_rdata;
               else if (r_count == LAST_WAIT)   r_fault <= 1'b1;
               else                             r_count <= r_count + 1'b1;
            end
            default: ;
         endcase
      end
   end

   load_extend u_load_extend (
      .i_data   (r_rdata),
      .i_size   (r_size),
      .i_signed (r_signed),
      .o_data   (w_ext)
   );

   assign d_ready   = (r_state != IDLE) | w_hit;
   assign stall     = ((r_state == IDLE) & w_hit) | (r_state == REQ);
   assign d_valid   = (r_state == RESP) & ~r_we;
   assign d_rdata   = ((r_state == RESP) && !r_we && !r_fault) ? w_ext : '0;
   assign bus_fault = (r_state == RESP) & r_fault;

   // The bus sees only latched values, and it is quiet outside REQ.
   assign bus_req   = (r_state == REQ);
   assign bus_we    = bus_req & r_we;
   assign bus_addr  = bus_req ? r_addr  : '0;
   assign bus_wdata = bus_req ? r_wdata : '0;
   assign bus_size  = bus_req ? r_size  : MEM_TYPE_NONE;

endmodule
